// File: rtl/enigma_stepper.sv
// Sequential front end for the combinational enigma core: accepts one letter,
// steps the three rotors (with the middle-rotor double step) and returns the result.
module enigma_stepper #(
  parameter int NOTCH1 = 16,
  parameter int NOTCH2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pos_load,
  input  logic [4:0]  pos_n1,
  input  logic [4:0]  pos_n2,
  input  logic [4:0]  pos_n3,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] in_letter,
  output logic [25:0] core_letter,
  output logic [4:0]  core_n1,
  output logic [4:0]  core_n2,
  output logic [4:0]  core_n3,
  input  logic [25:0] core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [25:0] out_letter,
  output logic        out_err,
  output logic        load_err
);

  typedef enum logic [1:0] {IDLE, STEP, ENC, OUT} state_t;

  state_t      state, state_nxt;
  logic [4:0]  n1, n2, n3;
  logic        err_r;
  logic        load_req, load_ok, accept, step_en, enc_en, out_done;
  logic        carry2, carry3;

  function automatic logic is_one_hot(input logic [25:0] v);
    return (v != '0) && ((v & (v - 26'd1)) == '0);
  endfunction

  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!pos_load && in_valid) state_nxt = STEP;
      STEP: state_nxt = ENC;
      ENC:  state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !pos_load;
    load_req = (state == IDLE) && pos_load;
    accept   = (state == IDLE) && !pos_load && in_valid;
    step_en  = (state == STEP);
    enc_en   = (state == ENC);
    out_done = (state == OUT) && out_ready;
  end

  // Both carries look at the pre-step positions, which yields the double step.
  assign carry2  = (n1 == 5'(NOTCH1)) || (n2 == 5'(NOTCH2));
  assign carry3  = (n2 == 5'(NOTCH2));
  assign load_ok = (pos_n1 <= 5'd25) && (pos_n2 <= 5'd25) && (pos_n3 <= 5'd25);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n1          <= '0;
      n2          <= '0;
      n3          <= '0;
      core_letter <= '0;
      out_letter  <= '0;
      out_valid   <= 1'b0;
      out_err     <= 1'b0;
      load_err    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (load_req) begin
        if (load_ok) begin
          n1 <= pos_n1;
          n2 <= pos_n2;
          n3 <= pos_n3;
        end else begin
          load_err <= 1'b1;
        end
      end
      if (accept) core_letter <= in_letter;
      if (step_en) begin
        err_r <= !is_one_hot(core_letter);
        if (is_one_hot(core_letter)) begin
          n1 <= wrap_inc(n1);
          if (carry2) n2 <= wrap_inc(n2);
          if (carry3) n3 <= wrap_inc(n3);
        end
      end
      if (enc_en) begin
        out_letter <= err_r ? '0 : core_out;
        out_err    <= err_r;
        out_valid  <= 1'b1;
      end
      if (out_done) begin
        out_valid <= 1'b0;
        out_err   <= 1'b0;
      end
    end
  end

  assign core_n1 = n1;
  assign core_n2 = n2;
  assign core_n3 = n3;

endmodule

// File: tb/tb_enigma_stepper.sv
// Randomized bench for enigma_stepper: a stub core plus a rotor-position model
// built from the stepping rules, checked at every phase of each transaction.
module tb_enigma_stepper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pos_load;
  logic [4:0]  pos_n1, pos_n2, pos_n3;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_letter;
  logic [25:0] core_letter;
  logic [4:0]  core_n1, core_n2, core_n3;
  logic [25:0] core_out;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_letter;
  logic        out_err;
  logic        load_err;

  int n_vec  = 0;
  int n_miss = 0;
  int m1, m2, m3;

  always #5 clk = ~clk;

  enigma_stepper dut (
    .clk(clk), .rst_n(rst_n), .pos_load(pos_load),
    .pos_n1(pos_n1), .pos_n2(pos_n2), .pos_n3(pos_n3),
    .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
    .core_letter(core_letter), .core_n1(core_n1), .core_n2(core_n2), .core_n3(core_n3),
    .core_out(core_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_letter(out_letter), .out_err(out_err), .load_err(load_err)
  );

  // Stand-in core: shifts the letter by a position-dependent amount.
  function automatic logic [25:0] core_fn(input logic [25:0] l, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c);
    int idx = -1;
    for (int i = 25; i >= 0; i--) if (l[i]) idx = i;
    if (idx < 0) return 26'h3FFFFFF;
    return 26'd1 << ((idx + int'(a) + 3 * int'(b) + 7 * int'(c)) % 26);
  endfunction

  assign core_out = core_fn(core_letter, core_n1, core_n2, core_n3);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_n1"}, 32'(core_n1), m1);
    chk({tag, "_n2"}, 32'(core_n2), m2);
    chk({tag, "_n3"}, 32'(core_n3), m3);
  endtask

  task automatic load(input int a, input int b, input int c, input bit with_v);
    bit ok;
    @(negedge clk);
    pos_load = 1'b1;
    pos_n1 = 5'(a); pos_n2 = 5'(b); pos_n3 = 5'(c);
    in_valid = with_v; in_letter = 26'h1;
    #1 chk("in_ready_load", 32'(in_ready), 32'd0);
    @(negedge clk);
    pos_load = 1'b0; in_valid = 1'b0;
    ok = (a <= 25) && (b <= 25) && (c <= 25);
    if (ok) begin m1 = a; m2 = b; m3 = c; end
    chk("load_err", 32'(load_err), 32'(!ok));
    chk_pos("load");
    chk("load_no_accept", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("load_err_clr", 32'(load_err), 32'd0);
    chk("in_ready_after_load", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [25:0] l, input int stall);
    logic [25:0] eo;
    bit oh, c2, c3;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_letter = l;
    @(negedge clk);
    in_valid = 1'b0; in_letter = 26'($urandom);
    pos_load = 1'b1; pos_n1 = 5'd3; pos_n2 = 5'd3; pos_n3 = 5'd3;
    chk("out_valid_step", 32'(out_valid), 32'd0);
    oh = ($countones(l) == 1);
    if (oh) begin
      c2 = (m1 == 16) || (m2 == 4);
      c3 = (m2 == 4);
      m1 = (m1 + 1) % 26;
      if (c2) m2 = (m2 + 1) % 26;
      if (c3) m3 = (m3 + 1) % 26;
    end
    eo = oh ? core_fn(l, 5'(m1), 5'(m2), 5'(m3)) : 26'd0;
    @(negedge clk);
    pos_load = 1'b0;
    chk_pos("enc");
    chk("core_letter_enc", 32'(core_letter), 32'(l));
    chk("out_valid_enc", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_letter", 32'(out_letter), 32'(eo));
    chk("out_err", 32'(out_err), 32'(!oh));
    chk("in_ready_out", 32'(in_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_letter", 32'(out_letter), 32'(eo));
      chk("stall_err", 32'(out_err), 32'(!oh));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clr", 32'(out_valid), 32'd0);
    chk("out_err_clr", 32'(out_err), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("core_letter_hold", 32'(core_letter), 32'(l));
    chk_pos("idle");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] l;
    int r;
    rst_n = 1'b0; pos_load = 1'b0; pos_n1 = '0; pos_n2 = '0; pos_n3 = '0;
    in_valid = 1'b0; in_letter = '0; out_ready = 1'b0;
    m1 = 0; m2 = 0; m3 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_letter", 32'(out_letter), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_core_letter", 32'(core_letter), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_pos("rst");

    send(26'h1, 0);
    chk("first_n1", 32'(core_n1), 32'd1);

    load(16, 0, 0, 1'b0);
    send(26'h20, 1);
    chk("notch1_n1", 32'(core_n1), 32'd17);
    chk("notch1_n2", 32'(core_n2), 32'd1);

    load(5, 4, 7, 1'b1);
    send(26'h100, 0);
    chk("dbl_n2", 32'(core_n2), 32'd5);
    chk("dbl_n3", 32'(core_n3), 32'd8);
    send(26'h8000, 0);
    chk("after_dbl_n1", 32'(core_n1), 32'd7);
    chk("after_dbl_n2", 32'(core_n2), 32'd5);

    load(25, 25, 25, 1'b0);
    send(26'h2000000, 0);
    chk("wrap_n1", 32'(core_n1), 32'd0);
    chk("wrap_n2", 32'(core_n2), 32'd25);
    load(16, 4, 25, 1'b0);
    send(26'h4, 0);
    chk("wrap3_n3", 32'(core_n3), 32'd0);
    chk("wrap3_n2", 32'(core_n2), 32'd5);

    send(26'h3, 0);
    chk("bad_n1", 32'(core_n1), 32'd17);
    send(26'h0, 1);
    load(1, 26, 1, 1'b0);
    chk("rej_n2", 32'(core_n2), 32'd5);
    send(26'h40, 5);

    // Reset while a letter sits in ENC: nothing of it may survive.
    @(negedge clk);
    in_valid = 1'b1; in_letter = 26'h8;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m1 = 0; m2 = 0; m3 = 0;
    #1;
    chk_pos("midrst");
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_core_letter", 32'(core_letter), 32'd0);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        case ($urandom_range(0, 2))
          0: load($urandom_range(26, 31), $urandom_range(0, 25), $urandom_range(0, 25), 1'b0);
          1: load($urandom_range(0, 25), $urandom_range(26, 31), $urandom_range(0, 25), 1'b0);
          default: load($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(26, 31), 1'b0);
        endcase
      end else if (r <= 2) begin
        load($urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25),
             1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 4) != 0) begin
          l = 26'd1 << $urandom_range(0, 25);
        end else begin
          l = 26'($urandom);
          if ($countones(l) == 1) l = 26'd0;
        end
        send(l, $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
